// File: rtl/unsig_seq_divide.sv
// Sequential unsigned restoring divider: one quotient bit per enabled clock,
// start/busy/done handshake, zero-divisor results flagged in a single cycle.
module unsig_seq_divide #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          sclr_n,
    input  logic          clken,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(DW - 1);

    state_t        state_q;
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   pr_q;
    logic [DW-1:0] wq_q;
    logic [4:0]    cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quot_q;
    logic [VW-1:0] rem_q;
    logic          dbz_q;

    logic [VW:0]   pr_shift_s;
    logic          ge_s;
    logic [VW:0]   pr_d;
    logic [DW-1:0] wq_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        pr_shift_s = {pr_q[VW-1:0], dvd_q[DW-1]};
        ge_s       = (pr_shift_s >= {1'b0, dvs_q});
        if (ge_s) begin
            pr_d = pr_shift_s - {1'b0, dvs_q};
        end else begin
            pr_d = pr_shift_s;
        end
        wq_d = {wq_q[DW-2:0], ge_s};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            wq_q    <= '0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else if (clken) begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        pr_q    <= '0;
                        wq_q    <= '0;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        state_q <= (divisor != '0) ? RUN : ZERO;
                    end
                end
                RUN: begin
                    pr_q  <= pr_d;
                    dvd_q <= {dvd_q[DW-2:0], 1'b0};
                    wq_q  <= wq_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        quot_q  <= wq_d;
                        rem_q   <= pr_d[VW-1:0];
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ZERO: begin
                    quot_q  <= '1;
                    rem_q   <= '0;
                    dbz_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
